uart_tx_frame: RTL and testbench

Parametrised UART transmitter, the next generation of the team's fixed 8N2 transmitter. Configurable data width, oversampling ratio and stop-bit count. Runtime-selectable parity (none/even/odd) and a ready/valid input handshake. Sits between the TX FIFO/command path and the o_tx pin, driven by the shared baud tick generator.

---
 rtl/uart_pkg.sv | 30 +++
 rtl/uart_bit_timer.sv | 30 +++
 rtl/uart_tx_frame.sv | 153 +++++++++++++++
 tb/tb_uart_tx_frame.sv | 379 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared constants for the parametrised UART transmitter: one-hot state
// encoding, parity-mode codes and the default oversampling ratio.
package uart_pkg;

  localparam int DEF_OVERSAMPLE = 16;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  localparam logic [4:0] ST_IDLE   = 5'b00001;
  localparam logic [4:0] ST_START  = 5'b00010;
  localparam logic [4:0] ST_DATA   = 5'b00100;
  localparam logic [4:0] ST_PARITY = 5'b01000;
  localparam logic [4:0] ST_STOP   = 5'b10000;

  typedef enum logic [4:0] {
    IDLE   = ST_IDLE,
    START  = ST_START,
    DATA   = ST_DATA,
    PARITY = ST_PARITY,
    STOP   = ST_STOP
  } state_t;

  // data_xor is the XOR reduction of the payload; odd parity inverts it
  function automatic logic parity_bit(input logic [1:0] mode, input logic data_xor);
    return (mode == PAR_ODD) ? ~data_xor : data_xor;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Tick counter for one bit period: counts i_tick up to i_terminal and
// strobes o_bit_end on the terminal tick, then restarts from zero.
module uart_bit_timer #(
  parameter int NB_CNT = 5
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_tick,
  input  logic              i_clear,
  input  logic [NB_CNT-1:0] i_terminal,
  output logic              o_bit_end
);

  logic [NB_CNT-1:0] cnt_q;
  logic              at_term;

  assign at_term   = (cnt_q == i_terminal);
  assign o_bit_end = i_tick && at_term && !i_clear;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      cnt_q <= '0;
    end else if (i_clear) begin
      cnt_q <= '0;
    end else if (i_tick) begin
      cnt_q <= at_term ? '0 : cnt_q + NB_CNT'(1);
    end
  end

endmodule

// File: rtl/uart_tx_frame.sv
// Parametrised UART transmitter: start, NB_DATA bits LSB first, optional parity,
// NB_STOP stop bits. Define UART_TX_BREAK_EN to add the i_break line-break input.
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int NB_DATA    = 8,
  parameter int OVERSAMPLE = DEF_OVERSAMPLE,
  parameter int NB_STOP    = 2,
  parameter int NB_CNT     = $clog2(OVERSAMPLE*NB_STOP)
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_tick,
`ifdef UART_TX_BREAK_EN
  input  logic               i_break,
`endif
  input  logic               i_valid,
  output logic               o_ready,
  input  logic [NB_DATA-1:0] i_data,
  input  logic [1:0]         i_parity_mode,
  output logic               o_tx,
  output logic               o_busy,
  output logic               o_done
);

  localparam int NB_IDX = $clog2(NB_DATA);
  localparam logic [NB_IDX-1:0] LAST_IDX  = NB_IDX'(NB_DATA-1);
  localparam logic [NB_CNT-1:0] TERM_BIT  = NB_CNT'(OVERSAMPLE-1);
  localparam logic [NB_CNT-1:0] TERM_STOP = NB_CNT'(OVERSAMPLE*NB_STOP-1);

  state_t             state, state_next;
  logic [NB_DATA-1:0] shift_q, shift_d;
  logic [NB_IDX-1:0]  idx_q, idx_d;
  logic               par_en_q, par_en_d;
  logic               par_bit_q, par_bit_d;
  logic               tx_q, tx_d;
  logic               done_q, done_d;
  logic               brk;
  logic               accept;
  logic               bit_end;
  logic               timer_clear;
  logic [NB_CNT-1:0]  term;

`ifdef UART_TX_BREAK_EN
  assign brk = i_break;
`else
  assign brk = 1'b0;
`endif

  assign o_ready     = (state == IDLE) && !brk;
  assign accept      = i_valid && o_ready;
  assign o_busy      = (state != IDLE);
  assign o_tx        = tx_q;
  assign o_done      = done_q;
  assign timer_clear = (state == IDLE);
  assign term        = (state == STOP) ? TERM_STOP : TERM_BIT;

  uart_bit_timer #(
    .NB_CNT(NB_CNT)
  ) u_bit_timer (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_tick    (i_tick),
    .i_clear   (timer_clear),
    .i_terminal(term),
    .o_bit_end (bit_end)
  );

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state     <= IDLE;
      shift_q   <= '0;
      idx_q     <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      tx_q      <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      state     <= state_next;
      shift_q   <= shift_d;
      idx_q     <= idx_d;
      par_en_q  <= par_en_d;
      par_bit_q <= par_bit_d;
      tx_q      <= tx_d;
      done_q    <= done_d;
    end
  end

  // tx_d is the line level for the next cycle, so o_tx follows the state change
  always_comb begin
    state_next = state;
    shift_d    = shift_q;
    idx_d      = idx_q;
    par_en_d   = par_en_q;
    par_bit_d  = par_bit_q;
    tx_d       = tx_q;
    done_d     = 1'b0;
    unique case (state)
      IDLE: begin
        tx_d = !brk;
        if (accept) begin
          state_next = START;
          tx_d       = 1'b0;
          shift_d    = i_data;
          idx_d      = '0;
          par_en_d   = !((i_parity_mode == PAR_NONE) || (i_parity_mode == 2'b11));
          par_bit_d  = parity_bit(i_parity_mode, ^i_data);
        end
      end
      START: begin
        if (bit_end) begin
          state_next = DATA;
          tx_d       = shift_q[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          if (idx_q == LAST_IDX) begin
            if (par_en_q) begin
              state_next = PARITY;
              tx_d       = par_bit_q;
            end else begin
              state_next = STOP;
              tx_d       = 1'b1;
            end
          end else begin
            shift_d = shift_q >> 1;
            idx_d   = idx_q + 1'b1;
            tx_d    = shift_q[1];
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_next = STOP;
          tx_d       = 1'b1;
        end
      end
      STOP: begin
        if (bit_end) begin
          state_next = IDLE;
          tx_d       = 1'b1;
          done_d     = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        tx_d       = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Scoreboard bench for uart_tx_frame: default-parameter instance plus a
// 7-bit / 1-stop / x8 instance; break tests run when UART_TX_BREAK_EN is defined.
module tb_uart_tx_frame;

  typedef struct {
    logic [15:0] bits;
    int          nbits;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] tdiv = 2'd0;
  logic       tick_en_a = 1'b1;
  logic       tick_en_b = 1'b1;
  logic       tick_a, tick_b;
  logic       mon_pause = 1'b0;

  logic       valid_a = 1'b0;
  logic [7:0] data_a = 8'h00;
  logic [1:0] mode_a = 2'b00;
  logic       ready_a, tx_a, busy_a, done_a;

  logic       valid_b = 1'b0;
  logic [6:0] data_b = 7'h00;
  logic [1:0] mode_b = 2'b00;
  logic       ready_b, tx_b, busy_b, done_b;

`ifdef UART_TX_BREAK_EN
  logic       brk = 1'b0;
`endif

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t q_a[$];
  exp_t q_b[$];

  always #5 clk = ~clk;
  always @(posedge clk) tdiv <= tdiv + 2'd1;
  assign tick_a = tick_en_a && (tdiv == 2'd3);
  assign tick_b = tick_en_b && (tdiv == 2'd3);

  uart_tx_frame u_dut_a (
    .i_clk        (clk),
    .i_reset      (rst),
    .i_tick       (tick_a),
`ifdef UART_TX_BREAK_EN
    .i_break      (brk),
`endif
    .i_valid      (valid_a),
    .o_ready      (ready_a),
    .i_data       (data_a),
    .i_parity_mode(mode_a),
    .o_tx         (tx_a),
    .o_busy       (busy_a),
    .o_done       (done_a)
  );

  uart_tx_frame #(
    .NB_DATA   (7),
    .OVERSAMPLE(8),
    .NB_STOP   (1)
  ) u_dut_b (
    .i_clk        (clk),
    .i_reset      (rst),
    .i_tick       (tick_b),
`ifdef UART_TX_BREAK_EN
    .i_break      (1'b0),
`endif
    .i_valid      (valid_b),
    .o_ready      (ready_b),
    .i_data       (data_b),
    .i_parity_mode(mode_b),
    .o_tx         (tx_b),
    .o_busy       (busy_b),
    .o_done       (done_b)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t mk_frame(input logic [8:0] d, input logic [1:0] mode,
                                    input int nd, input int ns);
    exp_t e;
    int   n;
    logic p;
    e.bits = '0;
    n = 1;
    p = 1'b0;
    for (int i = 0; i < nd; i++) begin
      e.bits[n] = d[i];
      p = p ^ d[i];
      n++;
    end
    if (mode == 2'b01) begin
      e.bits[n] = p;
      n++;
    end else if (mode == 2'b10) begin
      e.bits[n] = ~p;
      n++;
    end
    for (int i = 0; i < ns; i++) begin
      e.bits[n] = 1'b1;
      n++;
    end
    e.nbits = n;
    return e;
  endfunction

  // Decodes frames off the line, counting ticks from the start-bit fall to o_done.
  task automatic monitor(input int sel);
    logic        prev = 1'b1;
    bit          in_frame = 0;
    bit          chk_done_w = 0;
    int          j = 0;
    int          glitch = 0;
    int          k;
    int          os;
    logic [15:0] obs = '0;
    logic        tx, tk, dn, pause;
    exp_t        e;
    string       pfx;
    os  = (sel != 0) ? 8 : 16;
    pfx = (sel != 0) ? "B_" : "A_";
    forever begin
      @(negedge clk);
      tx    = (sel != 0) ? tx_b : tx_a;
      tk    = (sel != 0) ? tick_b : tick_a;
      dn    = (sel != 0) ? done_b : done_a;
      pause = (sel != 0) ? 1'b0 : mon_pause;
      if (rst) begin
        if (in_frame) begin
          in_frame = 0;
          if (sel != 0) begin
            if (q_b.size() > 0) void'(q_b.pop_front());
          end else begin
            if (q_a.size() > 0) void'(q_a.pop_front());
          end
        end
        chk_done_w = 0;
        prev = tx;
        continue;
      end
      if (chk_done_w) begin
        check_eq({pfx, "done_width"}, {31'd0, dn}, 32'd0);
        chk_done_w = 0;
      end
      if (!in_frame) begin
        if (prev && !tx && !pause) begin
          in_frame = 1;
          j = 0;
          glitch = 0;
          obs = '0;
        end
      end else if (dn) begin
        in_frame = 0;
        chk_done_w = 1;
        if (((sel != 0) ? q_b.size() : q_a.size()) == 0) begin
          check_eq({pfx, "unexpected_frame"}, 32'd1, 32'd0);
        end else begin
          e = (sel != 0) ? q_b.pop_front() : q_a.pop_front();
          check_eq({pfx, "frame_bits"}, {16'd0, obs}, {16'd0, e.bits});
          check_eq({pfx, "bit_stable"}, glitch, 0);
          check_eq({pfx, "frame_ticks"}, j, e.nbits * os);
        end
      end
      if (in_frame && tk) begin
        k = j / os;
        if (k < 16) begin
          if ((j % os) == 0) obs[k] = tx;
          else if (tx !== obs[k]) glitch++;
        end
        j++;
      end
      prev = tx;
    end
  endtask

  task automatic send_a(input logic [7:0] d, input logic [1:0] m);
    int t = 0;
    @(posedge clk);
    #1;
    valid_a = 1'b1;
    data_a  = d;
    mode_a  = m;
    q_a.push_back(mk_frame({1'b0, d}, m, 8, 2));
    do begin
      @(negedge clk);
      t++;
    end while (!ready_a && t < 5000);
    check_eq("A_accept", {31'd0, ready_a}, 32'd1);
    @(posedge clk);
    #1;
    valid_a = 1'b0;
    data_a  = 8'($urandom);
  endtask

  task automatic send_b(input logic [6:0] d, input logic [1:0] m);
    int t = 0;
    @(posedge clk);
    #1;
    valid_b = 1'b1;
    data_b  = d;
    mode_b  = m;
    q_b.push_back(mk_frame({2'b0, d}, m, 7, 1));
    do begin
      @(negedge clk);
      t++;
    end while (!ready_b && t < 5000);
    check_eq("B_accept", {31'd0, ready_b}, 32'd1);
    @(posedge clk);
    #1;
    valid_b = 1'b0;
  endtask

  task automatic drain(input int sel);
    int t = 0;
    while ((((sel != 0) ? q_b.size() : q_a.size()) != 0) && t < 4000) begin
      @(negedge clk);
      t++;
    end
    check_eq((sel != 0) ? "B_drain" : "A_drain",
             (sel != 0) ? q_b.size() : q_a.size(), 0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    fork
      monitor(0);
      monitor(1);
    join_none
  end

  initial begin
    int   t;
    int   bad;
    logic ref_tx;

    repeat (3) @(negedge clk);
    check_eq("rst_tx", {31'd0, tx_a}, 32'd1);
    check_eq("rst_ready", {31'd0, ready_a}, 32'd1);
    check_eq("rst_busy", {31'd0, busy_a}, 32'd0);
    check_eq("rst_done", {31'd0, done_a}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // plain frame, then even/odd parity and the reserved mode 11
    send_a(8'hA5, 2'b00);
    drain(0);
    send_a(8'h07, 2'b01);
    drain(0);
    send_a(8'h07, 2'b10);
    drain(0);
    send_a(8'h96, 2'b11);
    drain(0);

    // back-to-back with i_valid held high
    @(posedge clk);
    #1;
    valid_a = 1'b1;
    data_a  = 8'h01;
    mode_a  = 2'b00;
    q_a.push_back(mk_frame(9'h001, 2'b00, 8, 2));
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!ready_a && t < 100);
    @(posedge clk);
    #1;
    data_a = 8'h02;
    q_a.push_back(mk_frame(9'h002, 2'b00, 8, 2));
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!ready_a && t < 3000);
    check_eq("b2b_accept_in_done", {31'd0, done_a}, 32'd1);
    @(posedge clk);
    #1 valid_a = 1'b0;
    @(negedge clk);
    check_eq("b2b_no_gap", {31'd0, tx_a}, 32'd0);
    drain(0);

    // asynchronous reset during the third data bit
    send_a(8'hC3, 2'b00);
    repeat (220) @(posedge clk);
    #1;
    check_eq("pre_rst_tx", {31'd0, tx_a}, 32'd0);
    #1 rst = 1'b1;
    #1;
    check_eq("rst_async_tx", {31'd0, tx_a}, 32'd1);
    check_eq("rst_async_busy", {31'd0, busy_a}, 32'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check_eq("rst_abort_queue", q_a.size(), 0);
    send_a(8'h3C, 2'b01);
    drain(0);

    // requests and input changes while busy are ignored
    send_a(8'h5A, 2'b10);
    repeat (100) @(posedge clk);
    #1;
    valid_a = 1'b1;
    data_a  = 8'hFF;
    mode_a  = 2'b01;
    @(negedge clk);
    check_eq("busy_ready", {31'd0, ready_a}, 32'd0);
    check_eq("busy_flag", {31'd0, busy_a}, 32'd1);
    repeat (50) @(posedge clk);
    #1 valid_a = 1'b0;
    drain(0);
    check_eq("no_queued_frame", {31'd0, busy_a}, 32'd0);

    // 7-bit odd parity frame on the small instance, with a tick freeze
    send_b(7'h55, 2'b10);
    repeat (100) @(posedge clk);
    #1 tick_en_b = 1'b0;
    ref_tx = tx_b;
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (tx_b !== ref_tx || busy_b !== 1'b1) bad++;
    end
    check_eq("B_freeze_tx", bad, 0);
    #1 tick_en_b = 1'b1;
    drain(1);

`ifdef UART_TX_BREAK_EN
    mon_pause = 1'b1;
    @(posedge clk);
    #1 brk = 1'b1;
    @(posedge clk);
    bad = 0;
    repeat (50) begin
      @(negedge clk);
      if (tx_a !== 1'b0 || ready_a !== 1'b0) bad++;
    end
    check_eq("break_idle", bad, 0);
    @(posedge clk);
    #1 brk = 1'b0;
    @(negedge clk);
    check_eq("break_ready_back", {31'd0, ready_a}, 32'd1);
    @(negedge clk);
    check_eq("break_release_tx", {31'd0, tx_a}, 32'd1);
    mon_pause = 1'b0;

    send_a(8'h81, 2'b01);
    repeat (200) @(posedge clk);
    #1;
    brk = 1'b1;
    mon_pause = 1'b1;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!done_a && t < 3000);
    check_eq("brk_frame_done", {31'd0, done_a}, 32'd1);
    check_eq("brk_ready_after", {31'd0, ready_a}, 32'd0);
    @(negedge clk);
    check_eq("brk_tx_after", {31'd0, tx_a}, 32'd0);
    @(posedge clk);
    #1 brk = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("brk_end_tx", {31'd0, tx_a}, 32'd1);
    mon_pause = 1'b0;
    check_eq("brk_queue", q_a.size(), 0);
`endif

    repeat (5) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
